// File: rtl/gearbox_tx_sched_pkg.sv
// Shared PCS TX definitions: tracker states, 66b sync header encodings and
// the idle control block used when the encoder has nothing to send.
package gearbox_tx_sched_pkg;

  typedef enum logic {
    ALIGN = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam logic [1:0]  SYNC_DATA     = 2'b01;
  localparam logic [1:0]  SYNC_CTRL     = 2'b10;
  localparam logic [7:0]  CTRL_IDLE     = 8'h1E;
  localparam logic [1:0]  PCS_IDLE_HEAD = SYNC_CTRL;
  localparam logic [63:0] PCS_IDLE_DATA = {56'h0, CTRL_IDLE};

  function automatic int calc_shift_n(input int data_w, input int head_w);
    return data_w / head_w;
  endfunction

  localparam int PCS_SHIFT_N = calc_shift_n(64, 2);

endpackage

// File: rtl/gearbox_tx_sched_seq_track.sv
// Mirrors the gearbox sequence counter, predicts its stall cycle and drops
// lock whenever the observed accept pattern disagrees with the prediction.
module gearbox_seq_track
  import gearbox_tx_sched_pkg::*;
#(
  parameter int SHIFT_N = PCS_SHIFT_N,
  parameter int SEQ_W   = $clog2(SHIFT_N + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic gb_accept_i,
  output logic stall_next_o,
  output logic locked_o,
  output logic mismatch_o,
  output logic slip_err_o
);

  localparam logic [SEQ_W-1:0] SEQ_LAST = SEQ_W'(SHIFT_N);
  localparam logic [SEQ_W-1:0] SEQ_PRE  = SEQ_W'(SHIFT_N - 1);

  state_e           state_q, state_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             slip_q;
  logic             stall_pred;

  assign stall_pred   = (seq_q == SEQ_LAST);
  assign stall_next_o = (seq_q == SEQ_PRE);
  assign slip_err_o   = slip_q;

  // Seq 0 is the first accepting cycle after the stall, so a stall seen in
  // ALIGN restarts the count from zero.
  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    mismatch_o = 1'b0;
    locked_o   = 1'b0;
    case (state_q)
      ALIGN: begin
        if (!gb_accept_i) begin
          state_d = RUN;
          seq_d   = '0;
        end
      end
      RUN: begin
        locked_o = 1'b1;
        seq_d    = stall_pred ? '0 : seq_q + 1'b1;
        if (gb_accept_i == stall_pred) begin
          mismatch_o = 1'b1;
          state_d    = ALIGN;
          seq_d      = '0;
        end
      end
      default: state_d = ALIGN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ALIGN;
      seq_q   <= '0;
      slip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      slip_q  <= mismatch_o;
    end
  end

endmodule

// File: rtl/gearbox_tx_sched.sv
// Feeds 66b blocks into a TX gearbox that stalls once every SHIFT_N+1 cycles,
// giving upstream a one-cycle-early ready and filling gaps with idle blocks.
module gearbox_tx_sched
  import gearbox_tx_sched_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter int                HEAD_W    = 2,
  parameter logic [HEAD_W-1:0] IDLE_HEAD = HEAD_W'(PCS_IDLE_HEAD),
  parameter logic [DATA_W-1:0] IDLE_DATA = DATA_W'(PCS_IDLE_DATA),
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              up_valid_i,
  input  logic [HEAD_W-1:0] up_head_i,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              up_ready_o,
  input  logic              gb_accept_i,
  output logic [HEAD_W-1:0] gb_head_o,
  output logic [DATA_W-1:0] gb_data_o,
  output logic              locked_o,
  output logic              slip_err_o,
  output logic              err_sticky_o,
  input  logic              err_clr_i,
  output logic [CNT_W-1:0]  idle_cnt_o
);

  localparam int SHIFT_N = calc_shift_n(DATA_W, HEAD_W);

  logic              stall_next;
  logic              locked;
  logic              mismatch;
  logic              transfer;
  logic [HEAD_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sticky_q, sticky_d;

  gearbox_seq_track #(
    .SHIFT_N(SHIFT_N)
  ) u_seq_track (
    .clk         (clk),
    .reset       (reset),
    .gb_accept_i (gb_accept_i),
    .stall_next_o(stall_next),
    .locked_o    (locked),
    .mismatch_o  (mismatch),
    .slip_err_o  (slip_err_o)
  );

  assign up_ready_o   = locked & ~stall_next;
  assign transfer     = up_valid_i & up_ready_o;
  assign locked_o     = locked;
  assign gb_head_o    = head_q;
  assign gb_data_o    = data_q;
  assign idle_cnt_o   = cnt_q;
  assign err_sticky_o = sticky_q;

  // The register holds across the edge into the stall cycle because the
  // gearbox ignores its input then; a slip that lands there still flushes it.
  always_comb begin
    head_d   = head_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    sticky_d = mismatch | (sticky_q & ~err_clr_i);
    if (!locked) begin
      head_d = IDLE_HEAD;
      data_d = IDLE_DATA;
    end else if (transfer) begin
      head_d = up_head_i;
      data_d = up_data_i;
    end else if (stall_next) begin
      if (mismatch) begin
        head_d = IDLE_HEAD;
        data_d = IDLE_DATA;
      end
    end else begin
      head_d = IDLE_HEAD;
      data_d = IDLE_DATA;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q   <= IDLE_HEAD;
      data_q   <= IDLE_DATA;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: tb/tb_gearbox_tx_sched.sv
// Directed bench: a free-running gearbox phase model drives gb_accept_i while
// the encoder side pushes data, idles, slips and resets the scheduler.
module tb_gearbox_tx_sched;

  logic        clk;
  logic        reset;
  logic        up_valid_i;
  logic [1:0]  up_head_i;
  logic [63:0] up_data_i;
  logic        gb_accept_i;
  logic        err_clr_i;

  logic        up_ready_o, locked_o, slip_err_o, err_sticky_o;
  logic [1:0]  gb_head_o;
  logic [63:0] gb_data_o;
  logic [15:0] idle_cnt_o;

  logic        up_ready4, locked4, slip4, sticky4;
  logic [1:0]  head4;
  logic [63:0] data4;
  logic [3:0]  idle4;

  int          checks = 0;
  int          failures = 0;
  int          gbPos;
  int          expIdle;
  int          accepted;
  bit          expLocked;
  bit          expReady;
  logic [63:0] payload;
  logic [63:0] expData;
  logic [1:0]  expHead;

  gearbox_tx_sched dut (
    .clk(clk), .reset(reset),
    .up_valid_i(up_valid_i), .up_head_i(up_head_i), .up_data_i(up_data_i),
    .up_ready_o(up_ready_o), .gb_accept_i(gb_accept_i),
    .gb_head_o(gb_head_o), .gb_data_o(gb_data_o),
    .locked_o(locked_o), .slip_err_o(slip_err_o), .err_sticky_o(err_sticky_o),
    .err_clr_i(err_clr_i), .idle_cnt_o(idle_cnt_o)
  );

  gearbox_tx_sched #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .up_valid_i(up_valid_i), .up_head_i(up_head_i), .up_data_i(up_data_i),
    .up_ready_o(up_ready4), .gb_accept_i(gb_accept_i),
    .gb_head_o(head4), .gb_data_o(data4),
    .locked_o(locked4), .slip_err_o(slip4), .err_sticky_o(sticky4),
    .err_clr_i(err_clr_i), .idle_cnt_o(idle4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // gbPos is the real gearbox phase: 32 is its stall, 0 the first cycle after.
  task automatic applyStimulus(input logic valid, input logic [1:0] head,
                               input logic [63:0] data, input logic forceLow,
                               input logic clr);
    up_valid_i  = valid;
    up_head_i   = head;
    up_data_i   = data;
    err_clr_i   = clr;
    gb_accept_i = forceLow ? 1'b0 : (gbPos != 32);
    @(posedge clk);
    #1;
    gbPos = (gbPos == 32) ? 0 : gbPos + 1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) begin
      if (expLocked && gbPos != 31) expIdle++;
      applyStimulus(1'b0, 2'b00, 64'h0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    reset       = 1'b1;
    up_valid_i  = 1'b0;
    up_head_i   = 2'b00;
    up_data_i   = 64'h0;
    gb_accept_i = 1'b1;
    err_clr_i   = 1'b0;
    gbPos       = 27;
    expIdle     = 0;
    accepted    = 0;
    expLocked   = 1'b0;

    $display("[TB] reset values");
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst_locked", 64'(locked_o), 64'd0);
    checkOutput("rst_ready", 64'(up_ready_o), 64'd0);
    checkOutput("rst_head", 64'(gb_head_o), 64'd2);
    checkOutput("rst_data", gb_data_o, 64'h1E);
    checkOutput("rst_idle", 64'(idle_cnt_o), 64'd0);
    checkOutput("rst_slip", 64'(slip_err_o), 64'd0);
    checkOutput("rst_sticky", 64'(err_sticky_o), 64'd0);
    reset = 1'b0;

    $display("[TB] lock on first stall at cycle 5");
    for (int c = 0; c < 5; c++) applyStimulus(1'b0, 2'b00, 64'h0, 1'b0, 1'b0);
    checkOutput("align_unlocked", 64'(locked_o), 64'd0);
    checkOutput("align_idle_cnt", 64'(idle_cnt_o), 64'd0);
    applyStimulus(1'b0, 2'b00, 64'h0, 1'b0, 1'b0);
    expLocked = 1'b1;
    checkOutput("lock_cycle6", 64'(locked_o), 64'd1);
    checkOutput("lock_ready", 64'(up_ready_o), 64'd1);

    $display("[TB] streaming 66 cycles");
    payload = 64'h1000;
    expData = 64'h1E;
    expHead = 2'b10;
    for (int c = 0; c < 66; c++) begin
      expReady = (gbPos != 31);
      checkOutput("ready_sched", 64'(up_ready_o), 64'(expReady));
      if (up_ready_o) accepted++;
      applyStimulus(1'b1, 2'b01, payload, 1'b0, 1'b0);
      if (expReady) begin
        expData = payload;
        expHead = 2'b01;
        payload = payload + 64'd1;
      end
      checkOutput("stream_data", gb_data_o, expData);
      checkOutput("stream_head", 64'(gb_head_o), 64'(expHead));
      checkOutput("stream_slip", 64'(slip_err_o), 64'd0);
    end
    checkOutput("accept_count", 64'(accepted), 64'd64);
    checkOutput("stream_last", gb_data_o, 64'h103F);
    checkOutput("stream_no_idle", 64'(idle_cnt_o), 64'd0);

    $display("[TB] ten idle cycles");
    runIdle(10);
    checkOutput("idle_head", 64'(gb_head_o), 64'd2);
    checkOutput("idle_data", gb_data_o, 64'h1E);
    checkOutput("idle_cnt10", 64'(idle_cnt_o), 64'd10);
    checkOutput("idle_cnt4_10", 64'(idle4), 64'd10);

    $display("[TB] slip at seq 7");
    while (gbPos != 7) runIdle(1);
    expIdle++;
    applyStimulus(1'b0, 2'b00, 64'h0, 1'b1, 1'b0);
    expLocked = 1'b0;
    checkOutput("slip_pulse", 64'(slip_err_o), 64'd1);
    checkOutput("slip_sticky", 64'(err_sticky_o), 64'd1);
    checkOutput("slip_unlocked", 64'(locked_o), 64'd0);
    checkOutput("slip_ready", 64'(up_ready_o), 64'd0);
    checkOutput("slip_idle_data", gb_data_o, 64'h1E);
    applyStimulus(1'b0, 2'b00, 64'h0, 1'b0, 1'b1);
    checkOutput("slip_one_shot", 64'(slip_err_o), 64'd0);
    checkOutput("clr_alone", 64'(err_sticky_o), 64'd0);
    while (gbPos != 32) runIdle(1);
    checkOutput("pre_relock", 64'(locked_o), 64'd0);
    runIdle(1);
    expLocked = 1'b1;
    checkOutput("relock", 64'(locked_o), 64'd1);
    checkOutput("relock_idle", 64'(idle_cnt_o), 64'(expIdle));

    $display("[TB] clear racing a new slip");
    runIdle(3);
    expIdle++;
    applyStimulus(1'b0, 2'b00, 64'h0, 1'b1, 1'b1);
    expLocked = 1'b0;
    checkOutput("race_slip", 64'(slip_err_o), 64'd1);
    checkOutput("race_sticky", 64'(err_sticky_o), 64'd1);
    applyStimulus(1'b0, 2'b00, 64'h0, 1'b0, 1'b1);
    checkOutput("race_clr_next", 64'(err_sticky_o), 64'd0);
    while (gbPos != 32) runIdle(1);
    runIdle(1);
    expLocked = 1'b1;
    checkOutput("relock2", 64'(locked_o), 64'd1);
    checkOutput("idle_total", 64'(idle_cnt_o), 64'(expIdle));
    checkOutput("idle_cnt4_sat", 64'(idle4), 64'(expIdle > 15 ? 15 : expIdle));

    $display("[TB] reset mid-run");
    applyStimulus(1'b1, 2'b01, 64'hA5A5_0000_0000_0001, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b01, 64'hA5A5_0000_0000_0002, 1'b0, 1'b0);
    checkOutput("pre_rst_data", gb_data_o, 64'hA5A5_0000_0000_0002);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_locked", 64'(locked_o), 64'd0);
    checkOutput("mid_rst_ready", 64'(up_ready_o), 64'd0);
    checkOutput("mid_rst_head", 64'(gb_head_o), 64'd2);
    checkOutput("mid_rst_data", gb_data_o, 64'h1E);
    checkOutput("mid_rst_idle", 64'(idle_cnt_o), 64'd0);
    checkOutput("mid_rst_idle4", 64'(idle4), 64'd0);
    checkOutput("mid_rst_slip", 64'(slip_err_o), 64'd0);
    checkOutput("mid_rst_sticky", 64'(err_sticky_o), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
